// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage registers: per-boundary control/data
// payload structs, their bubble constants and the stage occupancy encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // ID/EX boundary
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_data_t;

  localparam int          ID_EX_CTRL_W      = $bits(id_ex_ctrl_t);
  localparam int          ID_EX_DATA_W      = $bits(id_ex_data_t);
  localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '0;

  // EX/MEM boundary
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_data_t;

  localparam int           EX_MEM_CTRL_W      = $bits(ex_mem_ctrl_t);
  localparam int           EX_MEM_DATA_W      = $bits(ex_mem_data_t);
  localparam ex_mem_ctrl_t EX_MEM_CTRL_BUBBLE = '0;

  // MEM/WB boundary
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mem_wb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_data_t;

  localparam int           MEM_WB_CTRL_W      = $bits(mem_wb_ctrl_t);
  localparam int           MEM_WB_DATA_W      = $bits(mem_wb_data_t);
  localparam mem_wb_ctrl_t MEM_WB_CTRL_BUBBLE = '0;

  function automatic logic [1:0] occupancy_of(input stage_state_t s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and saturating stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = ID_EX_DATA_W,
  parameter int                CTRL_W      = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit SKID_EN = (SKID != 0);

  stage_state_t      state;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              ready_q;
  logic              in_xfer;
  logic              out_xfer;
  logic              stall_inc;

  // With the skid buffer, in_ready is a flop mirroring "S is free", which
  // breaks the out_ready -> in_ready path; without it we fall back to the
  // classic combinational pass-through.
  assign in_ready  = SKID_EN ? ready_q : (out_ready | ~m_valid);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = m_valid & out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occupancy = occupancy_of(state);
  assign stall_inc = m_valid & ~out_ready & ~flush;

  // M_ctrl is reloaded with the bubble whenever M empties, so out_ctrl
  // shows a bubble without any output gating.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= CTRL_BUBBLE;
      s_data  <= '0;
      s_ctrl  <= CTRL_BUBBLE;
      ready_q <= 1'b1;
    end else if (flush) begin
      state   <= ST_EMPTY;
      m_valid <= 1'b0;
      m_data  <= in_data;
      m_ctrl  <= CTRL_BUBBLE;
      s_ctrl  <= CTRL_BUBBLE;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state   <= ST_ONE;
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_xfer && (out_xfer || !SKID_EN)) begin
            m_data <= in_data;
            m_ctrl <= in_ctrl;
          end else if (in_xfer) begin
            state   <= ST_FULL;
            s_data  <= in_data;
            s_ctrl  <= in_ctrl;
            ready_q <= 1'b0;
          end else if (out_xfer) begin
            state   <= ST_EMPTY;
            m_valid <= 1'b0;
            m_ctrl  <= CTRL_BUBBLE;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state   <= ST_ONE;
            m_data  <= s_data;
            m_ctrl  <= s_ctrl;
            s_ctrl  <= CTRL_BUBBLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          m_valid <= 1'b0;
          m_ctrl  <= CTRL_BUBBLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule
